// File: rtl/kara_seq_mul.sv
// Resource-shared Karatsuba multiplier: one (HI+1)-bit core computes the three
// partial products in turn, with valid/ready on both sides. Define KARA_SEQ_MUL_PIPE_EN to register the core inputs.
module kara_seq_mul #(
  parameter int W = 129
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out
);

  localparam int LO = W / 2;
  localparam int HI = W - LO;
  localparam int CW = HI + 1;
  localparam int PW = 2 * CW;
  localparam int XW = 2 * W + 2;

`ifdef KARA_SEQ_MUL_PIPE_EN
  typedef enum logic [3:0] {
    S_IDLE, S_M0A, S_M0B, S_M2A, S_M2B, S_M1A, S_M1B, S_CMB, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_M0, S_M2, S_M1, S_CMB, S_DONE
  } state_t;
`endif

  state_t          state;
  logic [LO-1:0]   a0, b0;
  logic [HI-1:0]   a1, b1;
  logic [PW-1:0]   p0, p2, pm;
  logic [CW-1:0]   sum_a, sum_b;
  logic [CW-1:0]   core_x, core_y;
  logic [PW-1:0]   prod;
  logic [XW-1:0]   mid;
  logic [2*W-1:0]  comb_res;

  assign sum_a = CW'(a0) + CW'(a1);
  assign sum_b = CW'(b0) + CW'(b1);

  // NOTE: every variable in an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    core_x = '0;
    core_y = '0;
    unique case (state)
`ifdef KARA_SEQ_MUL_PIPE_EN
      S_M0A: begin core_x = CW'(a0); core_y = CW'(b0); end
      S_M2A: begin core_x = CW'(a1); core_y = CW'(b1); end
      S_M1A: begin core_x = sum_a;   core_y = sum_b;   end
`else
      S_M0:  begin core_x = CW'(a0); core_y = CW'(b0); end
      S_M2:  begin core_x = CW'(a1); core_y = CW'(b1); end
      S_M1:  begin core_x = sum_a;   core_y = sum_b;   end
`endif
      default: ;
    endcase
  end

`ifdef KARA_SEQ_MUL_PIPE_EN
  logic [CW-1:0] cx_q, cy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= core_x;
      cy_q <= core_y;
    end
  end

  assign prod = PW'(cx_q) * PW'(cy_q);
`else
  assign prod = PW'(core_x) * PW'(core_y);
`endif

  // Middle term pm-p0-p2 is never negative, so the sum is exact in 2W+2 bits.
  assign mid      = XW'(pm) - XW'(p0) - XW'(p2);
  assign comb_res = (2*W)'(XW'(p0) + (mid << LO) + (XW'(p2) << (2 * LO)));

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand and partial-product registers are reset too, so an abandoned job leaves nothing behind.
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
      a0        <= '0;
      a1        <= '0;
      b0        <= '0;
      b1        <= '0;
      p0        <= '0;
      p2        <= '0;
      pm        <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            a0       <= a[LO-1:0];
            a1       <= a[W-1:LO];
            b0       <= b[LO-1:0];
            b1       <= b[W-1:LO];
            in_ready <= 1'b0;
`ifdef KARA_SEQ_MUL_PIPE_EN
            state    <= S_M0A;
`else
            state    <= S_M0;
`endif
          end
        end
`ifdef KARA_SEQ_MUL_PIPE_EN
        S_M0A: state <= S_M0B;
        S_M0B: begin p0 <= prod; state <= S_M2A; end
        S_M2A: state <= S_M2B;
        S_M2B: begin p2 <= prod; state <= S_M1A; end
        S_M1A: state <= S_M1B;
        S_M1B: begin pm <= prod; state <= S_CMB; end
`else
        S_M0:  begin p0 <= prod; state <= S_M2; end
        S_M2:  begin p2 <= prod; state <= S_M1; end
        S_M1:  begin pm <= prod; state <= S_CMB; end
`endif
        S_CMB: begin
          out       <= comb_res;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
